// File: rtl/rob_param_if.sv
// Reorder-buffer port bundle: allocate, writeback, retire/free-tag and status signals.
// The master side drives allocation and writebacks; the slave side is the ROB itself.
interface rob_param_if #(
    parameter int DEPTH    = 64,
    parameter int IDX_W    = $clog2(DEPTH),
    parameter int TAG_W    = 6,
    parameter int NUM_WB   = 4,
    parameter int RETIRE_W = 2
);
    logic                      enq_valid;
    logic                      enq_has_rd;
    logic [TAG_W-1:0]          enq_old_tag;
    logic                      enq_ready;
    logic [IDX_W-1:0]          enq_index;
    logic [NUM_WB-1:0]         wb_valid;
    logic [NUM_WB*IDX_W-1:0]   wb_index;
    logic [RETIRE_W-1:0]       retire_valid;
    logic [RETIRE_W*TAG_W-1:0] retire_tag;
    logic [2:0]                retire_num;
    logic [IDX_W:0]            count;
    logic                      empty;
    logic                      full;
    logic                      wb_err;

    modport master (
        output enq_valid, enq_has_rd, enq_old_tag, wb_valid, wb_index,
        input  enq_ready, enq_index, retire_valid, retire_tag, retire_num,
               count, empty, full, wb_err
    );

    modport slave (
        input  enq_valid, enq_has_rd, enq_old_tag, wb_valid, wb_index,
        output enq_ready, enq_index, retire_valid, retire_tag, retire_num,
               count, empty, full, wb_err
    );
endinterface

// File: rtl/rob_param.sv
// Parametrised in-order-retire reorder buffer; allocation at tail, completion from NUM_WB ports,
// up to RETIRE_W retires per cycle returning old tags. ROB_FLUSH_EN adds a synchronous flush port.
module rob_param #(
    parameter int DEPTH    = 64,
    parameter int IDX_W    = $clog2(DEPTH),
    parameter int TAG_W    = 6,
    parameter int NUM_WB   = 4,
    parameter int RETIRE_W = 2
) (
    input  logic         clk,
    input  logic         reset,
`ifdef ROB_FLUSH_EN
    input  logic         flush,
`endif
    rob_param_if.slave   io
);
    localparam int CW = IDX_W + 1;

    logic [DEPTH-1:0]          v_q, d_q, hr_q;
    logic [TAG_W-1:0]          tag_q [DEPTH];
    logic [IDX_W-1:0]          head_q, tail_q;
    logic [CW-1:0]             count_q, count_n;
    logic                      empty_q, full_q, err_q;
    logic [RETIRE_W-1:0]       rv_q, rv_n;
    logic [RETIRE_W*TAG_W-1:0] rt_q, rt_n;
    logic [2:0]                rnum_q, k;
    logic [DEPTH-1:0]          pop_mask, wb_set, enq_oh;
    logic                      enq_fire, wb_bad;

    // Full is the registered count, so an edge that both retires and would enqueue at full refuses the enqueue.
    assign enq_fire = io.enq_valid && !full_q;
    assign enq_oh   = enq_fire ? ({{(DEPTH-1){1'b0}}, 1'b1} << tail_q) : '0;
    assign count_n  = count_q + CW'(enq_fire) - CW'(k);

    always_comb begin
        logic [IDX_W-1:0] ridx;
        logic             run;
        ridx     = '0;
        run      = 1'b1;
        k        = '0;
        rv_n     = '0;
        rt_n     = '0;
        pop_mask = '0;
        for (int i = 0; i < RETIRE_W; i++) begin
            ridx = head_q + IDX_W'(i);
            if (run && v_q[ridx] && d_q[ridx]) begin
                k              = k + 3'd1;
                pop_mask[ridx] = 1'b1;
                rv_n[i]        = hr_q[ridx];
                rt_n[i*TAG_W +: TAG_W] = hr_q[ridx] ? tag_q[ridx] : '0;
            end else begin
                run = 1'b0;
            end
        end
    end

    always_comb begin
        logic [IDX_W-1:0] widx;
        widx   = '0;
        wb_set = '0;
        wb_bad = 1'b0;
        for (int p = 0; p < NUM_WB; p++) begin
            widx = io.wb_index[p*IDX_W +: IDX_W];
            if (io.wb_valid[p]) begin
                if (v_q[widx]) wb_set[widx] = 1'b1;
                else           wb_bad       = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q     <= '0;
            d_q     <= '0;
            hr_q    <= '0;
            for (int i = 0; i < DEPTH; i++) tag_q[i] <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
            rv_q    <= '0;
            rt_q    <= '0;
            rnum_q  <= '0;
`ifdef ROB_FLUSH_EN
        end else if (flush) begin
            v_q     <= '0;
            d_q     <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            rv_q    <= '0;
            rt_q    <= '0;
            rnum_q  <= '0;
`endif
        end else begin
            v_q     <= (v_q & ~pop_mask) | enq_oh;
            d_q     <= (d_q | wb_set) & ~pop_mask & ~enq_oh;
            if (enq_fire) begin
                hr_q[tail_q]  <= io.enq_has_rd;
                tag_q[tail_q] <= io.enq_old_tag;
                tail_q        <= tail_q + 1'b1;
            end
            head_q  <= head_q + IDX_W'(k);
            count_q <= count_n;
            empty_q <= (count_n == '0);
            full_q  <= (count_n == CW'(DEPTH));
            err_q   <= err_q | wb_bad;
            rv_q    <= rv_n;
            rt_q    <= rt_n;
            rnum_q  <= k;
        end
    end

    assign io.enq_ready    = !full_q;
    assign io.enq_index    = tail_q;
    assign io.retire_valid = rv_q;
    assign io.retire_tag   = rt_q;
    assign io.retire_num   = rnum_q;
    assign io.count        = count_q;
    assign io.empty        = empty_q;
    assign io.full         = full_q;
    assign io.wb_err       = err_q;
endmodule

// File: doc/rob_param.md
# rob_param

Parametrised reorder buffer for the out-of-order core. It allocates one entry per renamed instruction in program order and marks entries complete from any number of functional-unit or LSQ writeback ports. It retires up to RETIRE_W completed entries per cycle, strictly in order, and returns the superseded physical tags to the rename free list. It generalises the fixed 64-entry, 4-wakeup, 2-freed-tag ROB in depth, wakeup-port count and retire width, and adds full/empty flow control, occupancy reporting and an optional flush.

## Interface
Parameters:
- DEPTH, 64, entry count; must be a power of two, at least 4.
- IDX_W, $clog2(DEPTH), ROB index width.
- TAG_W, 6, physical tag width.
- NUM_WB, 4, number of writeback (wakeup) ports.
- RETIRE_W, 2, maximum entries retired per cycle; 1 ≤ RETIRE_W ≤ 4.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- enq_valid  in  1  allocate an entry this cycle.
- enq_has_rd  in  1  entry owns a destination; its old tag is freed at retire.
- enq_old_tag  in  TAG_W  previous physical mapping of rd.
- enq_ready  out  1  equals !full; combinational.
- enq_index  out  IDX_W  index given to the enqueuing instruction; always equals tail; combinational.
- wb_valid  in  NUM_WB  per-port completion strobe.
- wb_index  in  NUM_WB*IDX_W  packed ROB indices; port p uses bits [p*IDX_W +: IDX_W].
- retire_valid  out  RETIRE_W  registered; slot i frees a tag.
- retire_tag  out  RETIRE_W*TAG_W  registered; packed freed tags; 0 when the slot is invalid.
- retire_num  out  3  registered; number of entries popped on the last edge.
- count  out  IDX_W+1  registered occupancy.
- empty, full  out  1  registered; count==0 and count==DEPTH.
- wb_err  out  1  sticky; set when a writeback targets an invalid entry.

## Operation
- Per-entry state: valid, done, has_rd, old_tag. Pointers: head and tail, each IDX_W bits, wrapping modulo DEPTH naturally.
- Enqueue: fires when enq_valid && !full. On the edge, set entry[tail] to valid=1, done=0 and store has_rd and old_tag; increment tail.
- Writeback: for each port with wb_valid set, set done on entry[wb_index].
  - If the entry is not valid, ignore the write and set wb_err.
  - Duplicate indices across ports are OR-ed and harmless.
- Retire: scan entry[head+0 .. head+RETIRE_W-1] with modulo wrap.
  - k is the length of the leading run of entries with valid && done; the scan stops at the first entry that fails.
  - On the edge, clear those k entries and set head += k.
  - Register the outputs: retire_valid[i] = has_rd of popped entry i, retire_tag[i] = its old_tag, retire_num = k. Slots at i ≥ k are 0.
- Occupancy: count_next = count + enq_fire − k.
- full and enq_ready use the current registered count. An enqueue is refused at full even if a retire happens on the same edge.
- Retire uses done bits registered before the edge, so a writeback and a retire of the same entry cannot occur on the same edge.
- A writeback on the same cycle as an enqueue to that index sees valid=0 at that edge; it is ignored and sets wb_err.

## Timing
- Reset value of every output and all state: head=tail=0, all entries invalid, count=0, empty=1, full=0, enq_ready=1, enq_index=0, retire_valid=0, retire_tag=0, retire_num=0, wb_err=0.
- Reset asserted mid-operation discards all entries immediately.
- Latency:
  - Enqueue at edge N: the entry can be written back from cycle N+1.
  - Writeback at edge M: the earliest retire is edge M+1, and the freed tag is visible on retire_* during the cycle after edge M+1.
- Throughput: one enqueue per cycle, RETIRE_W retires per cycle.
- Wrap: the index after DEPTH−1 is 0, and enq_index continues through the wrap.

## Configuration
- ROB_FLUSH_EN defined: adds port flush (input, 1).
  - On an edge with flush=1, invalidate all entries and set head=tail=0, count=0, empty=1.
  - The next-cycle retire outputs are 0.
  - Enqueue and writeback in that cycle are ignored, and wb_err is not set.
  - flush has priority over everything except reset.
- ROB_FLUSH_EN undefined: the port does not exist, and entries leave only through retire.

## Test plan
- Reset, then enqueue tags 5, 6, 7 with has_rd=1 → enq_index 0, 1, 2 and count=3. Write back index 1 → no retire. Write back index 0 → next cycle retire_num=2, retire_tag slots {5,6}, count=1.
- Enqueue 64 entries → full=1, enq_ready=0. A 65th enq_valid is ignored and count stays 64.
- Complete and retire all 64, then enqueue 3 more → enq_index 0, 1, 2 after 63, and retire order is preserved across the wrap.
- Four consecutive done entries with RETIRE_W=2 → retire_num=2 on two successive cycles, in program order.
- An entry with has_rd=0 that is done at head → retire_num=1, retire_valid=0, count decrements. A writeback to an unallocated index → wb_err=1 and stays 1 until reset.
- With ROB_FLUSH_EN and 10 entries held, pulse flush concurrent with enq_valid and a writeback → count=0, empty=1, retire_valid=0, wb_err unchanged, next enq_index=0.
